id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the 5-stage MIPS core. It sits directly downstream of the `Register` file and captures the two read operands together with decode control. It bypasses a same-cycle writeback into those operands, detects load-use hazards against the instruction already in EX, and supports hold (stall) and bubble (flush) insertion. It also keeps a saturating count of inserted load-use bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 141 ++++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with writeback bypass,
// detects load-use hazards and inserts bubbles, with a saturating bubble counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [31:0]      id_pc4,
  input  logic [4:0]       id_readReg1,
  input  logic [4:0]       id_readReg2,
  input  logic [31:0]      id_readData1,
  input  logic [31:0]      id_readData2,
  input  logic [4:0]       id_writeReg,
  input  logic [31:0]      id_imm,
  input  logic [9:0]       id_ctrl,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_writeReg,
  input  logic [31:0]      wb_writeData,
  output logic             ex_valid,
  output logic [31:0]      ex_pc4,
  output logic [31:0]      ex_readData1,
  output logic [31:0]      ex_readData2,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_readReg1,
  output logic [4:0]       ex_readReg2,
  output logic [4:0]       ex_writeReg,
  output logic [9:0]       ex_ctrl,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  // Flow control: there is no valid/ready pair here. The ID instruction is
  // consumed on an edge where reset, flush, stall and load_use_stall are all
  // low; upstream must hold ID whenever stall or load_use_stall is high.

  localparam int MEMREAD_BIT = 8;

  logic             r_valid;
  logic [31:0]      r_pc4;
  logic [31:0]      r_readData1;
  logic [31:0]      r_readData2;
  logic [31:0]      r_imm;
  logic [4:0]       r_readReg1;
  logic [4:0]       r_readReg2;
  logic [4:0]       r_writeReg;
  logic [9:0]       r_ctrl;
  logic [CNT_W-1:0] r_bubble_count;

  logic             w_load_use;
  logic             w_byp_hit1;
  logic             w_byp_hit2;
  logic             w_refresh1;
  logic             w_refresh2;
  logic [31:0]      w_byp1;
  logic [31:0]      w_byp2;

  // $0 is hardwired zero in the register file, so it never takes a bypass.
  function automatic logic wb_hits(input logic [4:0] idx);
    return wb_regWrite && (wb_writeReg != 5'd0) && (wb_writeReg == idx);
  endfunction

  assign w_byp_hit1 = wb_hits(id_readReg1);
  assign w_byp_hit2 = wb_hits(id_readReg2);
  assign w_refresh1 = wb_hits(r_readReg1);
  assign w_refresh2 = wb_hits(r_readReg2);
  assign w_byp1     = w_byp_hit1 ? wb_writeData : id_readData1;
  assign w_byp2     = w_byp_hit2 ? wb_writeData : id_readData2;

  // Depends only on registered EX state and ID inputs; no path from wb_*.
  assign w_load_use = id_valid && r_valid && r_ctrl[MEMREAD_BIT] &&
                      (r_writeReg != 5'd0) &&
                      ((r_writeReg == id_readReg1) || (r_writeReg == id_readReg2));

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_pc4          <= '0;
      r_readData1    <= '0;
      r_readData2    <= '0;
      r_imm          <= '0;
      r_readReg1     <= '0;
      r_readReg2     <= '0;
      r_writeReg     <= '0;
      r_ctrl         <= '0;
      r_bubble_count <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_pc4       <= '0;
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_imm       <= '0;
      r_readReg1  <= '0;
      r_readReg2  <= '0;
      r_writeReg  <= '0;
      r_ctrl      <= '0;
    end else if (stall) begin
      // Held operands track writebacks so they are not stale on release.
      if (w_refresh1) r_readData1 <= wb_writeData;
      if (w_refresh2) r_readData2 <= wb_writeData;
    end else if (w_load_use) begin
      r_valid     <= 1'b0;
      r_pc4       <= '0;
      r_readData1 <= '0;
      r_readData2 <= '0;
      r_imm       <= '0;
      r_readReg1  <= '0;
      r_readReg2  <= '0;
      r_writeReg  <= '0;
      r_ctrl      <= '0;
      if (r_bubble_count != {CNT_W{1'b1}}) begin
        r_bubble_count <= r_bubble_count + CNT_W'(1);
      end
    end else begin
      r_valid     <= id_valid;
      r_pc4       <= id_pc4;
      r_readData1 <= w_byp1;
      r_readData2 <= w_byp2;
      r_imm       <= id_imm;
      r_readReg1  <= id_readReg1;
      r_readReg2  <= id_readReg2;
      r_writeReg  <= id_writeReg;
      r_ctrl      <= id_valid ? id_ctrl : 10'd0;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_pc4         = r_pc4;
  assign ex_readData1   = r_readData1;
  assign ex_readData2   = r_readData2;
  assign ex_imm         = r_imm;
  assign ex_readReg1    = r_readReg1;
  assign ex_readReg2    = r_readReg2;
  assign ex_writeReg    = r_writeReg;
  assign ex_ctrl        = r_ctrl;
  assign load_use_stall = w_load_use;
  assign bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked by a
// scoreboard fed from a behavioural model of the EX entry.
module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int W     = 1 + 32*4 + 5*3 + 10 + CNT_W;

  typedef struct packed {
    logic        v;
    logic [31:0] pc4;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [9:0]  ctrl;
  } ex_t;

  logic             clock_in;
  logic             reset;
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic [31:0]      id_pc4;
  logic [4:0]       id_readReg1;
  logic [4:0]       id_readReg2;
  logic [31:0]      id_readData1;
  logic [31:0]      id_readData2;
  logic [4:0]       id_writeReg;
  logic [31:0]      id_imm;
  logic [9:0]       id_ctrl;
  logic             wb_regWrite;
  logic [4:0]       wb_writeReg;
  logic [31:0]      wb_writeData;
  logic             ex_valid;
  logic [31:0]      ex_pc4;
  logic [31:0]      ex_readData1;
  logic [31:0]      ex_readData2;
  logic [31:0]      ex_imm;
  logic [4:0]       ex_readReg1;
  logic [4:0]       ex_readReg2;
  logic [4:0]       ex_writeReg;
  logic [9:0]       ex_ctrl;
  logic             load_use_stall;
  logic [CNT_W-1:0] bubble_count;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clock_in(clock_in), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc4(id_pc4),
    .id_readReg1(id_readReg1), .id_readReg2(id_readReg2),
    .id_readData1(id_readData1), .id_readData2(id_readData2),
    .id_writeReg(id_writeReg), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_readData1(ex_readData1), .ex_readData2(ex_readData2), .ex_imm(ex_imm),
    .ex_readReg1(ex_readReg1), .ex_readReg2(ex_readReg2), .ex_writeReg(ex_writeReg),
    .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  // ---------------- clock / reset ----------------
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  ex_t m_ex;
  int  m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic wb_hit(input logic [4:0] idx);
    return wb_regWrite && wb_writeReg != 0 && wb_writeReg == idx;
  endfunction

  // Reference: predicts the EX entry after the coming edge from current inputs.
  task automatic tick();
    logic lu;
    #1;
    lu = id_valid && m_ex.v && m_ex.ctrl[8] && m_ex.wr != 0 &&
         (m_ex.wr == id_readReg1 || m_ex.wr == id_readReg2);
    chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, lu});
    if (reset) begin
      m_ex  = '0;
      m_cnt = 0;
    end else if (flush) begin
      m_ex = '0;
    end else if (stall) begin
      if (wb_hit(m_ex.r1)) m_ex.d1 = wb_writeData;
      if (wb_hit(m_ex.r2)) m_ex.d2 = wb_writeData;
    end else if (lu) begin
      m_ex = '0;
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    end else begin
      m_ex.v    = id_valid;
      m_ex.pc4  = id_pc4;
      m_ex.d1   = wb_hit(id_readReg1) ? wb_writeData : id_readData1;
      m_ex.d2   = wb_hit(id_readReg2) ? wb_writeData : id_readData2;
      m_ex.imm  = id_imm;
      m_ex.r1   = id_readReg1;
      m_ex.r2   = id_readReg2;
      m_ex.wr   = id_writeReg;
      m_ex.ctrl = id_valid ? id_ctrl : 10'd0;
    end
    exp_q.push_back({m_ex, CNT_W'(m_cnt)});
    @(negedge clock_in);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clock_in) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {ex_valid, ex_pc4, ex_readData1, ex_readData2, ex_imm,
             ex_readReg1, ex_readReg2, ex_writeReg, ex_ctrl, bubble_count};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL ex_snapshot act=%h exp=%h t=%0t", act, exp, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    reset = 0; stall = 0; flush = 0; id_valid = 0; id_pc4 = 0;
    id_readReg1 = 0; id_readReg2 = 0; id_readData1 = 0; id_readData2 = 0;
    id_writeReg = 0; id_imm = 0; id_ctrl = 0;
    wb_regWrite = 0; wb_writeReg = 0; wb_writeData = 0;
  endtask

  task automatic rand_id();
    id_valid     = ($urandom_range(3, 0) != 0);
    id_pc4       = $urandom;
    id_readReg1  = 5'($urandom_range(7, 0));
    id_readReg2  = 5'($urandom_range(7, 0));
    id_readData1 = $urandom;
    id_readData2 = $urandom;
    id_writeReg  = 5'($urandom_range(7, 0));
    id_imm       = $urandom;
    id_ctrl      = 10'($urandom);
    wb_regWrite  = $urandom_range(1, 0) == 1;
    wb_writeReg  = 5'($urandom_range(7, 0));
    wb_writeData = $urandom;
  endtask

  task automatic load_instr(input logic [4:0] wr, input logic [4:0] rs);
    id_valid = 1; id_ctrl = 10'h340; id_writeReg = wr;
    id_readReg1 = rs; id_readReg2 = 5'd31; id_pc4 = 32'h40;
  endtask

  initial begin
    clear_inputs();
    m_ex  = '0;
    m_cnt = 0;
    reset = 1;
    @(negedge clock_in);
    @(negedge clock_in);

    // Reset held for two edges under random inputs.
    for (int i = 0; i < 2; i++) begin
      rand_id(); stall = $urandom_range(1, 0) == 1; flush = $urandom_range(1, 0) == 1;
      reset = 1;
      tick();
    end
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_cnt", {28'd0, bubble_count}, 32'd0);
    chk("reset_d1", ex_readData1, 32'd0);
    clear_inputs();

    // Plain capture.
    id_valid = 1; id_readReg1 = 5'b10101; id_readData1 = 32'hFFFF0000; id_ctrl = 10'h2A5;
    tick();
    chk("cap_d1", ex_readData1, 32'hFFFF0000);
    chk("cap_ctrl", {22'd0, ex_ctrl}, 32'h2A5);
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);

    // Writeback bypass, then $0 never bypassed.
    id_ctrl = 10'h200; id_readReg1 = 5'd1;
    wb_regWrite = 1; wb_writeReg = 5'b01010; wb_writeData = 32'h0000FFFF;
    id_readReg2 = 5'b01010; id_readData2 = 32'd0;
    tick();
    chk("byp_d2", ex_readData2, 32'h0000FFFF);
    wb_writeReg = 0; id_readReg2 = 0; wb_writeData = 32'hDEADBEEF; id_readData2 = 32'h13579BDF;
    tick();
    chk("byp_zero_d2", ex_readData2, 32'h13579BDF);
    clear_inputs();

    // Load-use: one bubble, then the consumer advances.
    load_instr(5'd8, 5'd1);
    tick();
    id_valid = 1; id_readReg1 = 5'd8; id_readReg2 = 5'd2; id_ctrl = 10'h200; id_writeReg = 5'd9;
    #1;
    chk("lu_assert", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_cnt_1", {28'd0, bubble_count}, 32'd1);
    tick();
    chk("lu_consumer_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_consumer_rr1", {27'd0, ex_readReg1}, 32'd8);
    chk("lu_release", {31'd0, load_use_stall}, 32'd0);
    load_instr(5'd0, 5'd1);
    tick();
    id_readReg1 = 5'd0; id_readReg2 = 5'd0; id_ctrl = 10'h200;
    #1;
    chk("lu_zero_dest", {31'd0, load_use_stall}, 32'd0);
    tick();

    // Flush + stall over a pending load-use: bubble, counter unchanged.
    load_instr(5'd8, 5'd1);
    tick();
    id_readReg1 = 5'd8; id_ctrl = 10'h200; stall = 1; flush = 1;
    #1;
    chk("prio_lu_pending", {31'd0, load_use_stall}, 32'd1);
    tick();
    chk("prio_valid", {31'd0, ex_valid}, 32'd0);
    chk("prio_ctrl", {22'd0, ex_ctrl}, 32'd0);
    chk("prio_cnt", {28'd0, bubble_count}, 32'd1);
    clear_inputs();

    // Stall refreshes held operand from writeback, leaves the rest alone.
    id_valid = 1; id_pc4 = 32'h100; id_readReg1 = 5'd3; id_readReg2 = 5'd4;
    id_readData1 = 32'h0; id_readData2 = 32'hAAAA5555; id_imm = 32'h77;
    id_writeReg = 5'd6; id_ctrl = 10'h2A5;
    tick();
    rand_id();
    stall = 1; wb_regWrite = 1; wb_writeReg = 5'd3; wb_writeData = 32'h12345678;
    tick();
    chk("stall_d1", ex_readData1, 32'h12345678);
    chk("stall_d2", ex_readData2, 32'hAAAA5555);
    chk("stall_pc4", ex_pc4, 32'h100);
    chk("stall_imm", ex_imm, 32'h77);
    chk("stall_ctrl", {22'd0, ex_ctrl}, 32'h2A5);
    chk("stall_wr", {27'd0, ex_writeReg}, 32'd6);
    clear_inputs();

    // Saturation: 2^CNT_W+3 load-use events.
    reset = 1;
    tick();
    reset = 0;
    load_instr(5'd8, 5'd8);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      tick();
      tick();
    end
    chk("sat_cnt", {28'd0, bubble_count}, 32'd15);
    tick();
    tick();
    chk("sat_hold", {28'd0, bubble_count}, 32'd15);
    clear_inputs();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_id();
      stall = ($urandom_range(7, 0) == 0);
      flush = ($urandom_range(15, 0) == 0);
      reset = ($urandom_range(63, 0) == 0);
      tick();
    end
    clear_inputs();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock_in);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
